// File: rtl/aer_spike_encoder.sv
// Rate-codes one stored 8-bit sample into AER spike/tick events over a 4-phase REQ/ACK link.
// Optional macro AER_ENC_TIMEOUT_EN adds a handshake timeout that aborts the sample and sets ERR.
module aer_spike_encoder #(
  parameter int          TIME_STEP      = 8,
  parameter int          INPUT_NEURON   = 784,
  parameter int          AER_IN_WIDTH   = 12,
  parameter int          PIX_ADDR_WIDTH = 10,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter int          ACK_TIMEOUT    = 1024
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      START,
  output logic [PIX_ADDR_WIDTH-1:0] PIX_ADDR,
  input  logic [7:0]                PIX_DATA,
  output logic [AER_IN_WIDTH-1:0]   AERIN_ADDR,
  output logic                      AERIN_REQ,
  input  logic                      AERIN_ACK,
  output logic                      BUSY,
  output logic                      DONE,
  output logic                      ERR
);

  localparam int PIX_W  = (INPUT_NEURON > 1) ? $clog2(INPUT_NEURON) : 1;
  localparam int STEP_W = $clog2(TIME_STEP) + 1;
  localparam logic [PIX_W-1:0]        LAST_PIX  = PIX_W'(INPUT_NEURON - 1);
  localparam logic [STEP_W-1:0]       LAST_STEP = STEP_W'(TIME_STEP - 1);
  localparam logic [AER_IN_WIDTH-1:0] TICK_ADDR = {2'b01, {(AER_IN_WIDTH-2){1'b0}}};

  generate
    if (LFSR_SEED == 16'h0000 || ACK_TIMEOUT < 1) begin : g_bad_param
      $error("aer_spike_encoder: LFSR_SEED must be nonzero and ACK_TIMEOUT at least 1");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, FETCH, CMP, REQ_H, REQ_L, TICK_H, TICK_L, FIN} state_t;

  state_t              state;
  logic [PIX_W-1:0]    pix;
  logic [STEP_W-1:0]   step;
  logic [15:0]         lfsr;
  logic                lfsr_fb;

  assign lfsr_fb  = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
  assign PIX_ADDR = PIX_ADDR_WIDTH'(pix);

`ifdef AER_ENC_TIMEOUT_EN
  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt;
  logic            in_req;
  logic            in_rel;
  logic            hs_wait;
  logic            to_hit;

  assign in_req  = (state == REQ_H) || (state == TICK_H);
  assign in_rel  = (state == REQ_L) || (state == TICK_L);
  assign hs_wait = (in_req && !(AERIN_REQ && AERIN_ACK)) || (in_rel && AERIN_ACK);
  assign to_hit  = (in_req || in_rel) && (to_cnt == TO_W'(ACK_TIMEOUT - 1));
`else
  assign ERR = 1'b0;
`endif

  // The comparison uses the LFSR byte held on entry to CMP; the shift happens on the same edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      pix        <= '0;
      step       <= '0;
      lfsr       <= LFSR_SEED;
      AERIN_ADDR <= '0;
      AERIN_REQ  <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
`ifdef AER_ENC_TIMEOUT_EN
      to_cnt     <= '0;
      ERR        <= 1'b0;
`endif
    end else begin
      DONE <= 1'b0;
`ifdef AER_ENC_TIMEOUT_EN
      to_cnt <= '0;
`endif
      case (state)
        IDLE: begin
          if (START) begin
            BUSY  <= 1'b1;
            pix   <= '0;
            step  <= '0;
            state <= FETCH;
`ifdef AER_ENC_TIMEOUT_EN
            ERR   <= 1'b0;
`endif
          end
        end
        FETCH: state <= CMP;
        CMP: begin
          lfsr <= {lfsr_fb, lfsr[15:1]};
          if (PIX_DATA > lfsr[7:0]) begin
            AERIN_ADDR <= AER_IN_WIDTH'(pix);
            AERIN_REQ  <= ~AERIN_ACK;
            state      <= REQ_H;
          end else if (pix == LAST_PIX) begin
            pix        <= '0;
            AERIN_ADDR <= TICK_ADDR;
            AERIN_REQ  <= ~AERIN_ACK;
            state      <= TICK_H;
          end else begin
            pix   <= pix + 1'b1;
            state <= FETCH;
          end
        end
        // REQ is only raised once ACK has been seen low, so a stale ACK never completes a phase.
        REQ_H, TICK_H: begin
          if (!AERIN_REQ) begin
            AERIN_REQ <= ~AERIN_ACK;
          end else if (AERIN_ACK) begin
            AERIN_REQ <= 1'b0;
            state     <= (state == REQ_H) ? REQ_L : TICK_L;
          end
        end
        REQ_L: begin
          if (!AERIN_ACK) begin
            if (pix == LAST_PIX) begin
              pix        <= '0;
              AERIN_ADDR <= TICK_ADDR;
              AERIN_REQ  <= 1'b1;
              state      <= TICK_H;
            end else begin
              pix   <= pix + 1'b1;
              state <= FETCH;
            end
          end
        end
        TICK_L: begin
          if (!AERIN_ACK) begin
            if (step == LAST_STEP) begin
              BUSY  <= 1'b0;
              DONE  <= 1'b1;
              state <= FIN;
            end else begin
              step  <= step + 1'b1;
              state <= FETCH;
            end
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
`ifdef AER_ENC_TIMEOUT_EN
      if (to_hit) begin
        AERIN_REQ <= 1'b0;
        ERR       <= 1'b1;
        DONE      <= 1'b1;
        BUSY      <= 1'b0;
        state     <= IDLE;
      end else if (hs_wait) begin
        to_cnt <= to_cnt + 1'b1;
      end
`endif
    end
  end

endmodule
